// File: rtl/controller_scan_multi.sv
// Self-scanning joypad interface: one shared latch/clock pair, one serial data line per socket.
// Decodes SNES / GAMETANK pads per port with a two-frame type filter and per-port change flags.
module controller_scan_multi #(
  parameter int FREQ      = 21_500_000,
  parameter int PORTS     = 2,
  parameter int BITS      = 16,
  parameter int HALF_US   = 6,
  parameter int LATCH_US  = 12,
  parameter int PERIOD_US = 16000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en,
  input  logic                 scan_now,
  output logic                 joy_strb,
  output logic                 joy_clk,
  input  logic [PORTS-1:0]     joy_data,
  output logic [12*PORTS-1:0]  buttons,
  output logic [PORTS-1:0]     ctrl_type,
  output logic [PORTS-1:0]     changed,
  output logic                 frame_valid,
  output logic                 busy
);

  localparam int TICK    = FREQ / 1_000_000;
  localparam int H       = TICK * HALF_US;
  localparam int L       = TICK * LATCH_US;
  localparam int P       = TICK * PERIOD_US;
  localparam int MAX_HL  = (H > L) ? H : L;
  localparam int MAX_CNT = (MAX_HL > P) ? MAX_HL : P;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int BW      = $clog2(BITS);

  localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
  localparam logic [CW-1:0] L_LAST   = CW'(L - 1);
  // WAIT also holds the commit cycle itself, so it runs one cycle past P-1.
  localparam logic [CW-1:0] P_LAST   = CW'(P);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_HIGH,
    S_CLK_LOW,
    S_WAIT
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [BW-1:0]   bit_cnt, bit_cnt_next;
  logic            shift_en, commit_en;

  logic [PORTS-1:0] sync1, sync2, pending, det;
  logic [BITS-1:0]  shift_buf [PORTS];
  logic [11:0]      decoded [PORTS];

  assign busy = (state == S_LATCH) || (state == S_CLK_HIGH) || (state == S_CLK_LOW);

  // Pin outputs are registered from the next state so they switch glitch-free with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      joy_strb <= 1'b0;
      joy_clk  <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_cnt  <= bit_cnt_next;
      joy_strb <= (state_next == S_LATCH);
      joy_clk  <= (state_next != S_CLK_LOW);
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CW'(1);
    bit_cnt_next = bit_cnt;
    shift_en     = 1'b0;
    commit_en    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (scan_en || scan_now) state_next = S_LATCH;
      end
      S_LATCH: begin
        if (cnt == L_LAST) begin
          state_next   = S_CLK_HIGH;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end
      end
      S_CLK_HIGH: begin
        if (cnt == H_LAST) begin
          state_next = S_CLK_LOW;
          cnt_next   = '0;
          shift_en   = 1'b1;
        end
      end
      S_CLK_LOW: begin
        if (cnt == H_LAST) begin
          cnt_next = '0;
          if (bit_cnt == BIT_LAST) begin
            commit_en  = 1'b1;
            state_next = S_WAIT;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
            state_next   = S_CLK_HIGH;
          end
        end
      end
      S_WAIT: begin
        if (scan_now) begin
          state_next = S_LATCH;
          cnt_next   = '0;
        end else if (cnt == P_LAST) begin
          cnt_next   = '0;
          state_next = scan_en ? S_LATCH : S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Any activity above the 12 SNES bits marks a GAMETANK pad, which only reports 8 buttons.
  always_comb begin
    det = '0;
    for (int p = 0; p < PORTS; p++) begin
      decoded[p] = '0;
      det[p]     = |shift_buf[p][BITS-1:12];
      decoded[p] = det[p] ? {4'b0, shift_buf[p][7:0]} : shift_buf[p][11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '1;
      sync2       <= '1;
      buttons     <= '0;
      ctrl_type   <= '0;
      pending     <= '0;
      changed     <= '0;
      frame_valid <= 1'b0;
      for (int p = 0; p < PORTS; p++) shift_buf[p] <= '0;
    end else begin
      sync1       <= joy_data;
      sync2       <= sync1;
      frame_valid <= commit_en;
      changed     <= '0;
      for (int p = 0; p < PORTS; p++) begin
        if (shift_en) shift_buf[p] <= {~sync2[p], shift_buf[p][BITS-1:1]};
        if (commit_en) begin
          buttons[12*p +: 12] <= decoded[p];
          changed[p]          <= (decoded[p] != buttons[12*p +: 12]);
          // Type flips only once two consecutive frames agree on the new type.
          if ((det[p] != ctrl_type[p]) && (det[p] == pending[p])) ctrl_type[p] <= det[p];
          pending[p] <= det[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_controller_scan_multi.sv
// Bench for controller_scan_multi: pad models on two ports, table of per-frame vectors,
// plus hand sequences for scan_now, WAIT timing and mid-scan reset.
module tb_controller_scan_multi;

  localparam int PORTS    = 2;
  localparam int SCAN_LEN = 24 + 2 * 12 * 16;
  localparam int WAIT_GAP = 400 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_en = 1'b0;
  logic scan_now = 1'b0;
  logic joy_strb, joy_clk, frame_valid, busy;
  logic [PORTS-1:0]    joy_data, ctrl_type, changed;
  logic [12*PORTS-1:0] buttons;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  controller_scan_multi #(
    .FREQ(2_000_000), .PORTS(PORTS), .BITS(16),
    .HALF_US(6), .LATCH_US(12), .PERIOD_US(200)
  ) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_now(scan_now),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_data(joy_data),
    .buttons(buttons), .ctrl_type(ctrl_type), .changed(changed),
    .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: strobe reloads bit 0, each rising joy_clk advances; line low = pressed.
  logic [31:0] pat [PORTS];
  logic        pres [PORTS];
  int          idx = 0;

  always @(posedge joy_strb) idx = 0;
  always @(posedge joy_clk) if (!joy_strb) idx = idx + 1;

  always_comb begin
    joy_data = '1;
    for (int p = 0; p < PORTS; p++)
      if (pres[p] && idx < 32) joy_data[p] = ~pat[p][idx];
  end

  typedef struct packed {
    logic [31:0] pat0;
    logic        pres0;
    logic [31:0] pat1;
    logic        pres1;
    logic [23:0] exp_buttons;
    logic [1:0]  exp_type;
    logic [1:0]  exp_changed;
  } vec_t;

  vec_t vecs [9];

  int          f_rise, f_fv, f_strb_high, f_falls, f_min_gap, f_max_gap, f_busy;
  logic        f_found;
  logic [23:0] f_buttons, e_buttons;
  logic [1:0]  f_type, f_changed;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pat[0]  = v.pat0;
    pres[0] = v.pres0;
    pat[1]  = v.pat1;
    pres[1] = v.pres1;
  endtask

  // Follows pins until the next frame_valid (bounded), recording scan timing.
  task automatic runFrame();
    logic prev_strb, prev_clk;
    int last_fall, gap;
    prev_strb = joy_strb;
    prev_clk  = joy_clk;
    f_found = 1'b0; f_rise = -1; f_fv = -1; f_strb_high = 0; f_falls = 0;
    f_min_gap = 1 << 30; f_max_gap = 0; f_busy = 0; last_fall = -1;
    for (int i = 0; i < 3000 && !f_found; i++) begin
      @(negedge clk);
      if (joy_strb && !prev_strb) f_rise = cyc;
      if (joy_strb) f_strb_high++;
      if (busy) f_busy++;
      if (!joy_clk && prev_clk) begin
        if (last_fall >= 0) begin
          gap = cyc - last_fall;
          if (gap < f_min_gap) f_min_gap = gap;
          if (gap > f_max_gap) f_max_gap = gap;
        end
        last_fall = cyc;
        f_falls++;
      end
      if (frame_valid) begin
        f_found   = 1'b1;
        f_fv      = cyc;
        f_buttons = buttons;
        f_type    = ctrl_type;
        f_changed = changed;
      end
      prev_strb = joy_strb;
      prev_clk  = joy_clk;
    end
  endtask

  task automatic countEvents(input int n, output int fv_cnt, output int rise_cnt);
    logic prev_strb;
    prev_strb = joy_strb;
    fv_cnt = 0;
    rise_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (joy_strb && !prev_strb) rise_cnt++;
      if (frame_valid) begin
        fv_cnt++;
        e_buttons = buttons;
      end
      prev_strb = joy_strb;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_fv, fvc, rc, c, r;
    vecs[0] = '{32'h0009, 1'b1, 32'hF0A5, 1'b1, 24'h0A5009, 2'b00, 2'b11};
    vecs[1] = '{32'h0009, 1'b1, 32'hF0A5, 1'b1, 24'h0A5009, 2'b10, 2'b00};
    vecs[2] = '{32'h0009, 1'b1, 32'hF0A5, 1'b1, 24'h0A5009, 2'b10, 2'b00};
    vecs[3] = '{32'h0000, 1'b0, 32'hF0A5, 1'b1, 24'h0A5000, 2'b10, 2'b01};
    vecs[4] = '{32'h0000, 1'b0, 32'h0C00, 1'b1, 24'hC00000, 2'b10, 2'b10};
    vecs[5] = '{32'h0FFF, 1'b1, 32'h0C00, 1'b1, 24'hC00FFF, 2'b00, 2'b01};
    vecs[6] = '{32'h0FFF, 1'b1, 32'h1F12, 1'b1, 24'h012FFF, 2'b00, 2'b10};
    vecs[7] = '{32'h8000, 1'b1, 32'h0012, 1'b1, 24'h012000, 2'b00, 2'b01};
    vecs[8] = '{32'h8000, 1'b1, 32'h0012, 1'b1, 24'h012000, 2'b01, 2'b00};

    applyStimulus(vecs[0]);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_strb", 32'(joy_strb), 0);
    checkOutput("rst_clk", 32'(joy_clk), 1);
    checkOutput("rst_buttons", 32'(buttons), 0);
    checkOutput("rst_type", 32'(ctrl_type), 0);
    checkOutput("rst_changed", 32'(changed), 0);
    checkOutput("rst_fv", 32'(frame_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    scan_en = 1'b1;

    prev_fv = 0;
    for (int i = 0; i < 9; i++) begin
      runFrame();
      checkOutput($sformatf("v%0d_found", i), 32'(f_found), 1);
      checkOutput($sformatf("v%0d_buttons", i), 32'(f_buttons), 32'(vecs[i].exp_buttons));
      checkOutput($sformatf("v%0d_type", i), 32'(f_type), 32'(vecs[i].exp_type));
      checkOutput($sformatf("v%0d_changed", i), 32'(f_changed), 32'(vecs[i].exp_changed));
      checkOutput($sformatf("v%0d_strb_len", i), 32'(f_strb_high), 24);
      checkOutput($sformatf("v%0d_clk_falls", i), 32'(f_falls), 16);
      checkOutput($sformatf("v%0d_min_gap", i), 32'(f_min_gap), 24);
      checkOutput($sformatf("v%0d_max_gap", i), 32'(f_max_gap), 24);
      checkOutput($sformatf("v%0d_scan_len", i), 32'(f_fv - f_rise), SCAN_LEN);
      checkOutput($sformatf("v%0d_busy_len", i), 32'(f_busy), SCAN_LEN);
      if (i > 0) checkOutput($sformatf("v%0d_wait_gap", i), 32'(f_rise - prev_fv), WAIT_GAP);
      prev_fv = f_fv;
      if (i < 8) applyStimulus(vecs[i + 1]);
    end

    // scan_en dropped in WAIT: drift to IDLE, then a single scan_now-triggered scan.
    scan_en = 1'b0;
    countEvents(500, fvc, rc);
    checkOutput("idle_fv", 32'(fvc), 0);
    checkOutput("idle_rise", 32'(rc), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_strb", 32'(joy_strb), 0);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    checkOutput("now_strb_next", 32'(joy_strb), 1);
    repeat (100) @(negedge clk);
    checkOutput("now_busy_mid", 32'(busy), 1);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    countEvents(1300, fvc, rc);
    checkOutput("now_fv_once", 32'(fvc), 1);
    checkOutput("now_no_restart", 32'(rc), 0);
    checkOutput("now_buttons", 32'(e_buttons), 32'h012000);
    checkOutput("now_back_idle", 32'(busy), 0);

    // scan_now at WAIT cycle 50 restarts the latch on the very next cycle.
    scan_en = 1'b1;
    runFrame();
    checkOutput("w50_found", 32'(f_found), 1);
    c = f_fv;
    while (cyc < c + 50) @(negedge clk);
    checkOutput("w50_strb_low", 32'(joy_strb), 0);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    checkOutput("w50_strb_next", 32'(joy_strb), 1);
    r = cyc;

    // Reset in the middle of bit 7's low phase aborts without committing.
    while (cyc < r + 208) @(negedge clk);
    checkOutput("bit7_clk_low", 32'(joy_clk), 0);
    reset = 1'b1;
    scan_en = 1'b0;
    @(negedge clk);
    checkOutput("abort_clk", 32'(joy_clk), 1);
    checkOutput("abort_strb", 32'(joy_strb), 0);
    checkOutput("abort_fv", 32'(frame_valid), 0);
    checkOutput("abort_buttons", 32'(buttons), 0);
    checkOutput("abort_type", 32'(ctrl_type), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    countEvents(600, fvc, rc);
    checkOutput("abort_no_commit", 32'(fvc), 0);
    checkOutput("abort_no_rise", 32'(rc), 0);
    checkOutput("abort_buttons_hold", 32'(buttons), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
